// File: rtl/spo2_ratio_calc_if.sv
// Sample/result bus between the calibration front end and spo2_ratio_calc.
// Beat-detector signals exist only when HR_EN is defined.
interface spo2_ratio_calc_if;
  logic        enable;
  logic        sample_valid;
  logic [7:0]  RED_ADC_Value;
  logic [7:0]  IR_ADC_Value;
  logic [9:0]  ratio;
  logic        ratio_valid;
  logic        ratio_err;
  logic        busy;
`ifdef HR_EN
  logic [11:0] beat_period;
  logic        beat_valid;
`endif

  modport master (
    output enable, sample_valid, RED_ADC_Value, IR_ADC_Value,
    input  ratio, ratio_valid, ratio_err, busy
`ifdef HR_EN
    , input beat_period, beat_valid
`endif
  );

  modport slave (
    input  enable, sample_valid, RED_ADC_Value, IR_ADC_Value,
    output ratio, ratio_valid, ratio_err, busy
`ifdef HR_EN
    , output beat_period, beat_valid
`endif
  );
endinterface

// File: rtl/spo2_ratio_calc.sv
// SpO2 ratio-of-ratios R = (AC_red/DC_red)/(AC_ir/DC_ir) in Q2.8 over a sample window.
// Optional IR beat detector (beat_period/beat_valid) is built when HR_EN is defined.
module spo2_ratio_calc #(
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned RATIO_MAX = 1023
) (
  input  logic           CLK,
  input  logic           rst_n,
  spo2_ratio_calc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_n;
  logic [11:0] cnt;
  logic [7:0]  red_min, red_max, ir_min, ir_max;
  logic [7:0]  red_min_n, red_max_n, ir_min_n, ir_max_n;
  logic [7:0]  s_red_min, s_red_max, s_ir_min, s_ir_max;
  logic        take, win_done;

  assign take     = bus.enable && bus.sample_valid;
  assign win_done = take && (cnt == 12'(WINDOW - 1));

  // Extremes including the current sample, so the window-closing sample is counted.
  always_comb begin
    red_min_n = (bus.RED_ADC_Value < red_min) ? bus.RED_ADC_Value : red_min;
    red_max_n = (bus.RED_ADC_Value > red_max) ? bus.RED_ADC_Value : red_max;
    ir_min_n  = (bus.IR_ADC_Value  < ir_min)  ? bus.IR_ADC_Value  : ir_min;
    ir_max_n  = (bus.IR_ADC_Value  > ir_max)  ? bus.IR_ADC_Value  : ir_max;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      red_min <= '1; red_max <= '0; ir_min <= '1; ir_max <= '0;
      cnt <= '0;
      s_red_min <= '0; s_red_max <= '0; s_ir_min <= '0; s_ir_max <= '0;
    end else if (!bus.enable) begin
      red_min <= '1; red_max <= '0; ir_min <= '1; ir_max <= '0;
      cnt <= '0;
    end else if (take) begin
      if (win_done) begin
        s_red_min <= red_min_n; s_red_max <= red_max_n;
        s_ir_min  <= ir_min_n;  s_ir_max  <= ir_max_n;
        red_min <= '1; red_max <= '0; ir_min <= '1; ir_max <= '0;
        cnt <= '0;
      end else begin
        red_min <= red_min_n; red_max <= red_max_n;
        ir_min  <= ir_min_n;  ir_max  <= ir_max_n;
        cnt <= cnt + 12'd1;
      end
    end
  end

  logic [7:0]  ac_r, ac_i, dc_r, dc_i;
  logic [8:0]  sum_r, sum_i;
  logic [23:0] quo;
  logic [15:0] den, rem;
  logic [4:0]  step;
  logic [16:0] rem_sh;
  logic        rem_ge;

  always_comb begin
    ac_r   = s_red_max - s_red_min;
    ac_i   = s_ir_max - s_ir_min;
    sum_r  = {1'b0, s_red_max} + {1'b0, s_red_min};
    sum_i  = {1'b0, s_ir_max} + {1'b0, s_ir_min};
    dc_r   = sum_r[8:1];
    dc_i   = sum_i[8:1];
    rem_sh = {rem, quo[23]};
    rem_ge = rem_sh >= {1'b0, den};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!bus.enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (win_done) state_n = MUL;
        MUL:     state_n = DIV;
        DIV:     if (step == 5'd23) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

  // quo holds the dividend and shifts quotient bits in from the LSB (restoring division).
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0; den <= '0; rem <= '0; step <= '0;
      bus.ratio <= '0; bus.ratio_err <= 1'b0; bus.ratio_valid <= 1'b0;
    end else begin
      bus.ratio_valid <= 1'b0;
      if (bus.enable) begin
        case (state)
          MUL: begin
            quo  <= {16'(ac_r) * 16'(dc_i), 8'h00};
            den  <= 16'(ac_i) * 16'(dc_r);
            rem  <= '0;
            step <= '0;
          end
          DIV: begin
            step <= step + 5'd1;
            rem  <= rem_ge ? 16'(rem_sh - {1'b0, den}) : rem_sh[15:0];
            quo  <= {quo[22:0], rem_ge};
          end
          DONE: begin
            bus.ratio_valid <= 1'b1;
            if (den == '0) begin
              bus.ratio     <= 10'(RATIO_MAX);
              bus.ratio_err <= 1'b1;
            end else begin
              bus.ratio     <= (quo > 24'(RATIO_MAX)) ? 10'(RATIO_MAX) : quo[9:0];
              bus.ratio_err <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HR_EN
  logic [7:0]  th;
  logic        th_valid, armed, have_first;
  logic [11:0] bcnt;
  logic [8:0]  th_sum;
  logic        above, below;

  always_comb begin
    th_sum = {1'b0, ir_max_n} + {1'b0, ir_min_n};
    above  = {1'b0, bus.IR_ADC_Value} > ({1'b0, th} + 9'd4);
    below  = ({1'b0, bus.IR_ADC_Value} + 9'd4) < {1'b0, th};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      th <= '0; th_valid <= 1'b0; armed <= 1'b0; have_first <= 1'b0; bcnt <= '0;
      bus.beat_period <= '0; bus.beat_valid <= 1'b0;
    end else if (!bus.enable) begin
      th <= '0; th_valid <= 1'b0; armed <= 1'b0; have_first <= 1'b0; bcnt <= '0;
      bus.beat_valid <= 1'b0;
    end else begin
      bus.beat_valid <= 1'b0;
      if (take && th_valid) begin
        if (armed && above) begin
          armed      <= 1'b0;
          have_first <= 1'b1;
          bcnt       <= '0;
          if (have_first) begin
            bus.beat_period <= bcnt + 12'd1;
            bus.beat_valid  <= 1'b1;
          end
        end else if (bcnt == 12'd4094) begin
          bus.beat_period <= 12'd4095;
          bus.beat_valid  <= 1'b1;
          bcnt <= '0; armed <= 1'b0; have_first <= 1'b0;
        end else begin
          bcnt <= bcnt + 12'd1;
          if (below) armed <= 1'b1;
        end
      end
      if (win_done) begin
        th       <= th_sum[8:1];
        th_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spo2_ratio_calc.sv
// Scoreboard bench for spo2_ratio_calc: windows are modelled from raw samples,
// expectations queued at window close and checked by a ratio_valid monitor.
module tb_spo2_ratio_calc;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  spo2_ratio_calc_if bus();

  spo2_ratio_calc #(.WINDOW(W), .RATIO_MAX(1023)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int ratio;
    int err;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   win_r[$];
  int   win_i[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   last_ratio = 0;
  int   last_err = 0;
  exp_t mon_e;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Ratio-of-ratios straight from the window's sample lists.
  function automatic exp_t ref_window();
    exp_t e;
    int rmin = 255, rmax = 0, imin = 255, imax = 0;
    int acr, aci, dcr, dci, num, den, q;
    foreach (win_r[k]) begin
      if (win_r[k] < rmin) rmin = win_r[k];
      if (win_r[k] > rmax) rmax = win_r[k];
      if (win_i[k] < imin) imin = win_i[k];
      if (win_i[k] > imax) imax = win_i[k];
    end
    acr = rmax - rmin;  aci = imax - imin;
    dcr = (rmax + rmin) / 2;  dci = (imax + imin) / 2;
    num = acr * dci * 256;
    den = aci * dcr;
    if (den == 0) begin
      e.ratio = 1023; e.err = 1;
    end else begin
      q = num / den;
      e.ratio = (q > 1023) ? 1023 : q;
      e.err = 0;
    end
    e.t = 0;
    return e;
  endfunction

  task automatic send(input int r, input int i);
    exp_t e;
    bus.sample_valid  = 1'b1;
    bus.RED_ADC_Value = r[7:0];
    bus.IR_ADC_Value  = i[7:0];
    if (bus.enable) begin
      win_r.push_back(r);
      win_i.push_back(i);
      if (win_r.size() == W) begin
        e = ref_window();
        e.t = cyc + 27;
        exp_q.push_back(e);
        win_r.delete();
        win_i.delete();
      end
    end
    @(posedge CLK); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      idle(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic alt_window(input int r0, input int r1, input int i0, input int i1);
    for (int k = 0; k < W; k++) send((k % 2) ? r1 : r0, (k % 2) ? i1 : i0);
  endtask

  always @(negedge CLK) begin
    if (rst_n && bus.ratio_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got ratio %0d with no pending window (cycle %0d)", bus.ratio, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("ratio", int'(bus.ratio), mon_e.ratio);
        check("ratio_err", int'(bus.ratio_err), mon_e.err);
        check("latency", cyc, mon_e.t);
        last_ratio = mon_e.ratio;
        last_err   = mon_e.err;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int base;
    bus.enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.RED_ADC_Value = '0;
    bus.IR_ADC_Value = '0;

    #12;
    check("reset_ratio", int'(bus.ratio), 0);
    check("reset_valid", int'(bus.ratio_valid), 0);
    check("reset_err", int'(bus.ratio_err), 0);
    check("reset_busy", int'(bus.busy), 0);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    idle(2);
    bus.enable = 1'b1;
    idle(1);

    alt_window(100, 140, 80, 160);
    idle(1);
    check("busy_during_compute", int'(bus.busy), 1);
    wait_drain();
    check("nominal_ratio", int'(bus.ratio), 128);
    check("busy_after", int'(bus.busy), 0);

    alt_window(100, 140, 120, 120);
    wait_drain();
    check("zero_den_ratio", int'(bus.ratio), 1023);
    check("zero_den_err", int'(bus.ratio_err), 1);
    alt_window(100, 140, 80, 160);
    wait_drain();
    check("err_cleared", int'(bus.ratio_err), 0);

    alt_window(28, 228, 123, 133);
    wait_drain();
    check("sat_ratio", int'(bus.ratio), 1023);
    check("sat_err", int'(bus.ratio_err), 0);

    alt_window(90, 90, 80, 160);
    wait_drain();
    check("zero_ac_ratio", int'(bus.ratio), 0);

    // Back-to-back windows, distinct extreme as first sample of the second window.
    base = n_valid;
    for (int k = 0; k < 3 * W; k++) begin
      if (k == W) send(255, 60);
      else send($urandom_range(100, 140), $urandom_range(80, 160));
    end
    wait_drain();
    check("b2b_pulses", n_valid - base, 3);

    // Abort mid-divide while a new window is partially collected.
    base = n_valid;
    for (int k = 0; k < W; k++) send($urandom_range(90, 150), $urandom_range(70, 170));
    for (int k = 0; k < 5; k++) send($urandom_range(90, 150), $urandom_range(70, 170));
    idle(5);
    bus.enable = 1'b0;
    void'(exp_q.pop_back());
    win_r.delete();
    win_i.delete();
    idle(40);
    send(200, 10);
    idle(3);
    check("abort_no_valid", n_valid - base, 0);
    check("abort_ratio_hold", int'(bus.ratio), last_ratio);
    check("abort_err_hold", int'(bus.ratio_err), last_err);
    check("abort_busy", int'(bus.busy), 0);
    bus.enable = 1'b1;
    idle(1);
    for (int k = 0; k < W; k++) send($urandom_range(90, 150), $urandom_range(70, 170));
    wait_drain();
    check("reenable_pulses", n_valid - base, 1);

    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < W; k++) begin
        send($urandom_range(0, 255), $urandom_range(0, 255));
        idle($urandom_range(0, 2));
      end
    end
    wait_drain();

    idle(5);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
